// File: rtl/dmem_access_unit.sv
// Load/store unit between the core data port and a single-port word RAM without byte enables.
// Sub-word stores are done as read-modify-write; illegal or misaligned accesses are rejected with a fault pulse.
module dmem_access_unit #(
    parameter int ADDR_W = 10
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              req_read,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [2:0]        req_funct3,
    output logic              stall,
    output logic [31:0]       rdata,
    output logic              fault,
    output logic [ADDR_W-3:0] ram_addr,
    output logic              ram_re,
    output logic              ram_we,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RMW_RD,
        S_RMW_WR,
        S_DONE
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [2:0]        r_funct3;
    logic [15:0]       r_wdata;
    logic [31:0]       r_merge;
    logic [31:0]       r_rdata;
    logic              r_fault;

    logic              w_req;
    logic              w_start;
    logic              w_badFunct3;
    logic              w_misaligned;
    logic              w_fault;
    logic              w_startLoad;
    logic              w_startSw;
    logic              w_startRmw;
    logic              w_busy;
    logic [7:0]        w_byte;
    logic [15:0]       w_half;
    logic [31:0]       w_loadData;
    logic [31:0]       w_merge;

    assign w_req   = req_read | req_write;
    assign w_start = (r_state == S_IDLE) & w_req & ~RST;

    // Stores only exist as B/H/W; any funct3 with bit 2 set is load-only or undefined.
    assign w_badFunct3  = (req_funct3 == 3'b011) | (req_funct3[2:1] == 2'b11)
                        | (req_write & req_funct3[2]);
    assign w_misaligned = ((req_funct3[1:0] == 2'b01) & req_addr[0])
                        | ((req_funct3 == 3'b010) & (req_addr[1:0] != 2'b00));
    assign w_fault      = (req_read & req_write) | w_badFunct3 | w_misaligned;

    assign w_startLoad = w_start & ~w_fault & req_read;
    assign w_startSw   = w_start & ~w_fault & req_write & (req_funct3 == 3'b010);
    assign w_startRmw  = w_start & ~w_fault & req_write & ~req_funct3[1];

    assign w_busy = (r_state == S_LOAD) | (r_state == S_RMW_RD) | (r_state == S_RMW_WR);

    assign stall     = ~RST & (w_start | w_busy);
    assign ram_re    = w_startLoad | w_startRmw;
    assign ram_we    = w_startSw | ((r_state == S_RMW_WR) & ~RST);
    assign ram_addr  = w_start ? req_addr[ADDR_W-1:2] : r_addr[ADDR_W-1:2];
    assign ram_wdata = w_startSw ? req_wdata : r_merge;
    assign rdata     = r_rdata;
    assign fault     = r_fault;

    always_comb begin
        w_byte = ram_rdata[7:0];
        case (r_addr[1:0])
            2'd0:    w_byte = ram_rdata[7:0];
            2'd1:    w_byte = ram_rdata[15:8];
            2'd2:    w_byte = ram_rdata[23:16];
            default: w_byte = ram_rdata[31:24];
        endcase
        w_half = r_addr[1] ? ram_rdata[31:16] : ram_rdata[15:0];

        w_loadData = ram_rdata;
        case (r_funct3)
            3'b000:  w_loadData = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_loadData = {{16{w_half[15]}}, w_half};
            3'b100:  w_loadData = {24'd0, w_byte};
            3'b101:  w_loadData = {16'd0, w_half};
            default: w_loadData = ram_rdata;
        endcase
    end

    // Merge the latched store data into the word just read back from RAM.
    always_comb begin
        w_merge = ram_rdata;
        if (r_funct3[0]) begin
            if (r_addr[1]) w_merge[31:16] = r_wdata;
            else           w_merge[15:0]  = r_wdata;
        end else begin
            case (r_addr[1:0])
                2'd0:    w_merge[7:0]   = r_wdata[7:0];
                2'd1:    w_merge[15:8]  = r_wdata[7:0];
                2'd2:    w_merge[23:16] = r_wdata[7:0];
                default: w_merge[31:24] = r_wdata[7:0];
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state  <= S_IDLE;
            r_addr   <= '0;
            r_funct3 <= '0;
            r_wdata  <= '0;
            r_merge  <= '0;
            r_rdata  <= '0;
            r_fault  <= 1'b0;
        end else begin
            r_fault <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_req) begin
                        r_addr   <= req_addr;
                        r_funct3 <= req_funct3;
                        r_wdata  <= req_wdata[15:0];
                        if (w_fault) begin
                            r_fault <= 1'b1;
                            r_state <= S_DONE;
                        end else if (req_read) begin
                            r_state <= S_LOAD;
                        end else if (req_funct3 == 3'b010) begin
                            r_state <= S_DONE;
                        end else begin
                            r_state <= S_RMW_RD;
                        end
                    end
                end
                S_LOAD: begin
                    r_rdata <= w_loadData;
                    r_state <= S_DONE;
                end
                S_RMW_RD: begin
                    r_merge <= w_merge;
                    r_state <= S_RMW_WR;
                end
                S_RMW_WR: r_state <= S_DONE;
                S_DONE:   r_state <= S_IDLE;
                default:  r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_access_unit.sv
// Directed bench for dmem_access_unit: a vector table of accesses against a behavioural
// 1-cycle-latency RAM, plus hand-written reset, fault-pulse and request-change sequences.
module tb_dmem_access_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic        memInit;
    logic        reqRead;
    logic        reqWrite;
    logic [9:0]  reqAddr;
    logic [31:0] reqWdata;
    logic [2:0]  reqFunct3;
    logic        stall;
    logic [31:0] rdata;
    logic        fault;
    logic [7:0]  ramAddr;
    logic        ramRe;
    logic        ramWe;
    logic [31:0] ramWdata;
    logic [31:0] ramRdata = 32'd0;
    logic [31:0] mem [0:255];
    int          errors = 0;
    int          checks = 0;
    int          weCount = 0;
    int          weBefore;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [9:0]  addr;
        logic [31:0] wdata;
        logic [2:0]  f3;
        int          expStall;
        logic        expFault;
        logic [3:0]  expRe;
        logic [3:0]  expWe;
        logic [31:0] expWdata;
        logic [31:0] expRdata;
    } vec_t;

    vec_t vecs [0:24];
    vec_t v;

    dmem_access_unit #(.ADDR_W(10)) dut (
        .CLK        (clock),
        .RST        (reset),
        .req_read   (reqRead),
        .req_write  (reqWrite),
        .req_addr   (reqAddr),
        .req_wdata  (reqWdata),
        .req_funct3 (reqFunct3),
        .stall      (stall),
        .rdata      (rdata),
        .fault      (fault),
        .ram_addr   (ramAddr),
        .ram_re     (ramRe),
        .ram_we     (ramWe),
        .ram_wdata  (ramWdata),
        .ram_rdata  (ramRdata)
    );

    always #5 clock = ~clock;

    // Behavioural RAM: one-cycle read latency, preloaded while memInit is high.
    always @(posedge clock) begin
        if (memInit) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'd0;
            mem[4] <= 32'h8034_12F0;
            mem[2] <= 32'h1122_3344;
        end else begin
            if (ramWe) begin
                mem[ramAddr] <= ramWdata;
                weCount      <= weCount + 1;
            end
            if (ramRe) ramRdata <= mem[ramAddr];
        end
    end

    function automatic vec_t mkVec(input logic rd, input logic wr, input logic [9:0] addr,
                                   input logic [31:0] wdata, input logic [2:0] f3,
                                   input int st, input logic flt, input logic [3:0] re,
                                   input logic [3:0] we, input logic [31:0] ewd,
                                   input logic [31:0] erd);
        vec_t r;
        r.rd = rd; r.wr = wr; r.addr = addr; r.wdata = wdata; r.f3 = f3;
        r.expStall = st; r.expFault = flt; r.expRe = re; r.expWe = we;
        r.expWdata = ewd; r.expRdata = erd;
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Runs one access from the IDLE cycle to the DONE cycle; optionally scrambles the request pins after cycle 0.
    task automatic applyStimulus(input vec_t s, input string tag, input bit scramble);
        int          n;
        logic [3:0]  reSeen;
        logic [3:0]  weSeen;
        logic [31:0] wdSeen;
        bit          both;
        bit          addrBad;
        bit          doneStrobe;
        n = 0; reSeen = '0; weSeen = '0; wdSeen = '0; both = 0; addrBad = 0;
        @(negedge clock);
        reqRead = s.rd; reqWrite = s.wr; reqAddr = s.addr; reqWdata = s.wdata; reqFunct3 = s.f3;
        #1;
        while (stall && n < 20) begin
            if (n < 4) begin
                reSeen[n[1:0]] = ramRe;
                weSeen[n[1:0]] = ramWe;
            end
            if (ramRe && ramWe) both = 1;
            if ((ramRe || ramWe) && ramAddr != s.addr[9:2]) addrBad = 1;
            if (ramWe) wdSeen = ramWdata;
            n++;
            @(negedge clock);
            if (scramble) begin
                reqRead = 1'b1; reqAddr = 10'h030; reqWdata = 32'h1111_1111; reqFunct3 = 3'b010;
            end
            #1;
        end
        doneStrobe = ramRe || ramWe;
        checkOutput({tag, " stall cycles"}, n, s.expStall);
        checkOutput({tag, " fault"}, {31'd0, fault}, {31'd0, s.expFault});
        checkOutput({tag, " rdata"}, rdata, s.expRdata);
        checkOutput({tag, " re pattern"}, {28'd0, reSeen}, {28'd0, s.expRe});
        checkOutput({tag, " we pattern"}, {28'd0, weSeen}, {28'd0, s.expWe});
        checkOutput({tag, " strobe in done"}, {31'd0, doneStrobe}, 32'd0);
        checkOutput({tag, " re and we together"}, {31'd0, both}, 32'd0);
        checkOutput({tag, " ram addr"}, {31'd0, addrBad}, 32'd0);
        if (s.expWe != 4'd0) checkOutput({tag, " ram wdata"}, wdSeen, s.expWdata);
        reqRead = 1'b0; reqWrite = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        //                 rd    wr    addr    wdata          f3    st flt re       we       ram wdata      rdata
        vecs[0]  = mkVec(1'b1, 1'b0, 10'h010, 32'h0,         3'b000, 2, 0, 4'b0001, 4'b0000, 32'h0,         32'hFFFF_FFF0);
        vecs[1]  = mkVec(1'b1, 1'b0, 10'h013, 32'h0,         3'b100, 2, 0, 4'b0001, 4'b0000, 32'h0,         32'h0000_0080);
        vecs[2]  = mkVec(1'b1, 1'b0, 10'h012, 32'h0,         3'b001, 2, 0, 4'b0001, 4'b0000, 32'h0,         32'hFFFF_8034);
        vecs[3]  = mkVec(1'b1, 1'b0, 10'h010, 32'h0,         3'b101, 2, 0, 4'b0001, 4'b0000, 32'h0,         32'h0000_12F0);
        vecs[4]  = mkVec(1'b1, 1'b0, 10'h010, 32'h0,         3'b010, 2, 0, 4'b0001, 4'b0000, 32'h0,         32'h8034_12F0);
        vecs[5]  = mkVec(1'b1, 1'b0, 10'h011, 32'h0,         3'b000, 2, 0, 4'b0001, 4'b0000, 32'h0,         32'h0000_0012);
        vecs[6]  = mkVec(1'b0, 1'b1, 10'h009, 32'hFFFF_FFAB, 3'b000, 3, 0, 4'b0001, 4'b0100, 32'h1122_AB44, 32'h0000_0012);
        vecs[7]  = mkVec(1'b1, 1'b0, 10'h008, 32'h0,         3'b010, 2, 0, 4'b0001, 4'b0000, 32'h0,         32'h1122_AB44);
        vecs[8]  = mkVec(1'b0, 1'b1, 10'h00A, 32'h1234_CAFE, 3'b001, 3, 0, 4'b0001, 4'b0100, 32'hCAFE_AB44, 32'h1122_AB44);
        vecs[9]  = mkVec(1'b1, 1'b0, 10'h00A, 32'h0,         3'b101, 2, 0, 4'b0001, 4'b0000, 32'h0,         32'h0000_CAFE);
        vecs[10] = mkVec(1'b0, 1'b1, 10'h008, 32'hDEAD_BEEF, 3'b010, 1, 0, 4'b0000, 4'b0001, 32'hDEAD_BEEF, 32'h0000_CAFE);
        vecs[11] = mkVec(1'b1, 1'b0, 10'h008, 32'h0,         3'b010, 2, 0, 4'b0001, 4'b0000, 32'h0,         32'hDEAD_BEEF);
        vecs[12] = mkVec(1'b1, 1'b0, 10'h006, 32'h0,         3'b010, 1, 1, 4'b0000, 4'b0000, 32'h0,         32'hDEAD_BEEF);
        vecs[13] = mkVec(1'b0, 1'b1, 10'h003, 32'h5555_5555, 3'b001, 1, 1, 4'b0000, 4'b0000, 32'h0,         32'hDEAD_BEEF);
        vecs[14] = mkVec(1'b1, 1'b0, 10'h000, 32'h0,         3'b011, 1, 1, 4'b0000, 4'b0000, 32'h0,         32'hDEAD_BEEF);
        vecs[15] = mkVec(1'b1, 1'b1, 10'h000, 32'h0,         3'b010, 1, 1, 4'b0000, 4'b0000, 32'h0,         32'hDEAD_BEEF);
        vecs[16] = mkVec(1'b0, 1'b1, 10'h000, 32'h6666_6666, 3'b100, 1, 1, 4'b0000, 4'b0000, 32'h0,         32'hDEAD_BEEF);
        vecs[17] = mkVec(1'b1, 1'b0, 10'h00B, 32'h0,         3'b001, 1, 1, 4'b0000, 4'b0000, 32'h0,         32'hDEAD_BEEF);
        vecs[18] = mkVec(1'b0, 1'b1, 10'h020, 32'h1234_5678, 3'b010, 1, 0, 4'b0000, 4'b0001, 32'h1234_5678, 32'hDEAD_BEEF);
        vecs[19] = mkVec(1'b1, 1'b0, 10'h020, 32'h0,         3'b010, 2, 0, 4'b0001, 4'b0000, 32'h0,         32'h1234_5678);
        vecs[20] = mkVec(1'b0, 1'b1, 10'h022, 32'h0000_005A, 3'b000, 3, 0, 4'b0001, 4'b0100, 32'h125A_5678, 32'h1234_5678);
        vecs[21] = mkVec(1'b1, 1'b0, 10'h022, 32'h0,         3'b000, 2, 0, 4'b0001, 4'b0000, 32'h0,         32'h0000_005A);
        vecs[22] = mkVec(1'b1, 1'b0, 10'h020, 32'h0,         3'b001, 2, 0, 4'b0001, 4'b0000, 32'h0,         32'h0000_5678);
        vecs[23] = mkVec(1'b1, 1'b0, 10'h000, 32'h0,         3'b110, 1, 1, 4'b0000, 4'b0000, 32'h0,         32'h0000_5678);
        vecs[24] = mkVec(1'b1, 1'b0, 10'h023, 32'h0,         3'b000, 2, 0, 4'b0001, 4'b0000, 32'h0,         32'h0000_0012);

        // Reset with a request present: strobes and stall must stay low.
        reset = 1'b1; memInit = 1'b1;
        reqRead = 1'b1; reqWrite = 1'b0; reqAddr = 10'h010; reqWdata = 32'd0; reqFunct3 = 3'b010;
        repeat (3) @(negedge clock);
        #1;
        checkOutput("in reset stall", {31'd0, stall}, 32'd0);
        checkOutput("in reset ram_re", {31'd0, ramRe}, 32'd0);
        checkOutput("in reset ram_we", {31'd0, ramWe}, 32'd0);
        reqRead = 1'b0;
        @(negedge clock);
        reset = 1'b0; memInit = 1'b0;
        #1;
        checkOutput("reset stall", {31'd0, stall}, 32'd0);
        checkOutput("reset rdata", rdata, 32'd0);
        checkOutput("reset fault", {31'd0, fault}, 32'd0);
        checkOutput("reset ram_re", {31'd0, ramRe}, 32'd0);
        checkOutput("reset ram_we", {31'd0, ramWe}, 32'd0);
        checkOutput("reset ram_addr", {24'd0, ramAddr}, 32'd0);
        checkOutput("reset ram_wdata", ramWdata, 32'd0);

        for (int i = 0; i < 25; i++) applyStimulus(vecs[i], $sformatf("vec%0d", i), 1'b0);

        // Request pins move after cycle 0; the store must still use the cycle-0 address and data.
        v = mkVec(1'b0, 1'b1, 10'h024, 32'h0000_0077, 3'b000, 3, 0, 4'b0001, 4'b0100, 32'h0000_0077, 32'h0000_0012);
        applyStimulus(v, "scramble sb", 1'b1);
        v = mkVec(1'b1, 1'b0, 10'h024, 32'h0, 3'b010, 2, 0, 4'b0001, 4'b0000, 32'h0, 32'h0000_0077);
        applyStimulus(v, "scramble readback", 1'b0);
        v = mkVec(1'b1, 1'b0, 10'h030, 32'h0, 3'b010, 2, 0, 4'b0001, 4'b0000, 32'h0, 32'h0000_0000);
        applyStimulus(v, "scramble untouched", 1'b0);

        // Fault must be a single-cycle pulse.
        v = mkVec(1'b1, 1'b0, 10'h000, 32'h0, 3'b111, 1, 1, 4'b0000, 4'b0000, 32'h0, 32'h0000_0000);
        applyStimulus(v, "fault f3 111", 1'b0);
        @(negedge clock);
        #1;
        checkOutput("fault pulse width", {31'd0, fault}, 32'd0);

        // Reset while an SH sits in RMW_RD: no write may follow.
        weBefore = weCount;
        @(negedge clock);
        reqWrite = 1'b1; reqRead = 1'b0; reqAddr = 10'h020; reqWdata = 32'h0000_BEEF; reqFunct3 = 3'b001;
        #1;
        checkOutput("abort cycle0 stall", {31'd0, stall}, 32'd1);
        checkOutput("abort cycle0 ram_re", {31'd0, ramRe}, 32'd1);
        @(negedge clock);
        #1;
        checkOutput("abort rmw_rd stall", {31'd0, stall}, 32'd1);
        reset = 1'b1;
        #1;
        checkOutput("abort in reset stall", {31'd0, stall}, 32'd0);
        checkOutput("abort in reset ram_we", {31'd0, ramWe}, 32'd0);
        checkOutput("abort in reset ram_re", {31'd0, ramRe}, 32'd0);
        reqWrite = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        #1;
        checkOutput("abort after stall", {31'd0, stall}, 32'd0);
        checkOutput("abort after rdata", rdata, 32'd0);
        checkOutput("abort after fault", {31'd0, fault}, 32'd0);
        checkOutput("abort after ram_we", {31'd0, ramWe}, 32'd0);
        checkOutput("abort after ram_re", {31'd0, ramRe}, 32'd0);
        checkOutput("abort after ram_addr", {24'd0, ramAddr}, 32'd0);
        checkOutput("abort after ram_wdata", ramWdata, 32'd0);
        repeat (3) @(negedge clock);
        #1;
        checkOutput("abort write count", weCount, weBefore);
        v = mkVec(1'b1, 1'b0, 10'h020, 32'h0, 3'b010, 2, 0, 4'b0001, 4'b0000, 32'h0, 32'h125A_5678);
        applyStimulus(v, "after abort lw", 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dmem_access_unit.md
# dmem_access_unit

Load/store unit between the CPU core's data-memory port and a single-port synchronous data RAM without byte enables. It performs byte/halfword/word loads with sign or zero extension, does read-modify-write for sub-word stores, and flags misaligned or illegal accesses. It stalls the core for the duration of each access.

## Interface
- ADDR_W, 10, byte-address width from the core; RAM word address is ADDR_W-2 bits.
- CLK  in  1  sole clock, rising edge.
- RST  in  1  reset; synchronous, active-high.
- req_read  in  1  load request (core MemRead).
- req_write  in  1  store request (core MemWrite).
- req_addr  in  ADDR_W  byte address (core ALU result).
- req_wdata  in  32  store data, right-aligned (rs2).
- req_funct3  in  3  access size: 000 B, 001 H, 010 W, 100 BU, 101 HU (BU/HU are loads only).
- stall  out  1  core must hold PC and request stable while high.
- rdata  out  32  load result; valid in the DONE cycle, held until the next load completes.
- fault  out  1  one-cycle pulse in the DONE cycle of a rejected access.
- ram_addr  out  ADDR_W-2  word address, equal to req_addr[ADDR_W-1:2] (registered copy after cycle 0).
- ram_re  out  1  read strobe; data is returned on ram_rdata the next cycle.
- ram_we  out  1  write strobe for the full word.
- ram_wdata  out  32  write word.
- ram_rdata  in  32  RAM read data, 1-cycle latency.

## Operation
- FSM states: IDLE, LOAD, RMW_RD, RMW_WR, DONE.
- IDLE, no request: stall=0 and all RAM strobes are 0.
- IDLE, request present: stall=1 combinationally. Address, funct3 and wdata are latched. Request pins are ignored after this cycle.
- Fault checks, evaluated in IDLE:
  - req_read and req_write both high.
  - Undefined funct3: 011, 110, 111, or store with 100/101.
  - Misaligned: H/HU with addr[0]=1, or W with addr[1:0]≠0.
  - On fault: no RAM access, go to DONE, fault=1 in DONE. rdata is unchanged.
- Load: IDLE drives ram_re=1, then LOAD. LOAD selects the lane (byte = addr[1:0]*8, half = addr[1]*16, little-endian) and extends it:
  - B/H: sign-extend.
  - BU/HU: zero-extend.
  - W: pass through.
  - The result is registered into rdata; go to DONE.
- SW: IDLE drives ram_we=1 with ram_wdata=req_wdata, then DONE.
- SB/SH: IDLE drives ram_re=1, then RMW_RD.
  - RMW_RD merges the low byte/half of the latched wdata into ram_rdata at the selected lane and registers the merged word; go to RMW_WR.
  - RMW_WR drives ram_we=1 with the merged word; go to DONE.
- DONE: stall=0 and the core retires the instruction. Unconditional transition to IDLE.
- A request present in IDLE right after DONE starts a new access (back-to-back).

## Timing
- Stall cycles per access, then one DONE cycle:
  - SW: 1.
  - Load: 2.
  - SB/SH: 3.
  - Fault: 1.
- Reset values: state IDLE, stall 0, rdata 0, fault 0, ram_re/ram_we 0, ram_addr 0, ram_wdata 0, internal latches 0.
- While RST is high, ram_re, ram_we and stall are forced to 0.
- Reset mid-operation aborts the access. No write is issued in or after the reset cycle, including from RMW_WR. The state machine restarts in IDLE.
- ram_re and ram_we are never high in the same cycle. At most one RAM write per store.
- Address wrap: none. ram_addr uses the top ADDR_W-2 bits only.

## Test plan
- Load: RAM[word 4]=0x8034_12F0; LB at addr 0x010 -> stall 2 cycles, rdata=0xFFFF_FFF0. LBU at 0x013 -> rdata=0x0000_0080. LH at 0x012 -> rdata=0xFFFF_8034.
- SB: RAM[word 2]=0x1122_3344; SB 0xAB at 0x009 -> ram_re cycle 0, ram_we cycle 2 with 0x1122_AB44, stall 3 cycles. SW 0xDEAD_BEEF at 0x008 -> single ram_we cycle 0, 1 stall cycle.
- Faults: LW at 0x006, SH at 0x003, funct3=011, read+write together -> each gives fault=1 for one cycle after 1 stall cycle, no RAM strobe, rdata unchanged.
- Back-to-back: SW to 0x020 then LW from 0x020 -> load returns the stored word, no idle gap beyond DONE.
- Reset in RMW_RD of an SH -> no ram_we ever asserted, all outputs at reset values the following cycle, next request is serviced normally.
- Request pins change after cycle 0 -> the access uses the cycle-0 address and data.
